// File: rtl/placement_pkg.sv
// Shared definitions for the grid placer: walk states, the unplaced-node marker
// and the default memory/coordinate/accumulator widths.
package placement_pkg;

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_COORD_W = 32;
  localparam int DEF_SUM_W   = 32;

  // A node whose coordinate reads back as all-ones has not been placed yet.
  localparam logic [DEF_COORD_W-1:0] UNPLACED = '1;

  typedef enum logic [3:0] {
    IDLE,
    E_RD,
    E_WT,
    A_RD,
    A_WT,
    B_RD,
    B_WT,
    ACC,
    FIN
  } state_t;

endpackage

// File: rtl/manhattan_len.sv
// Combinational edge length |dx|+|dy|-1 clamped at 0, plus an unplaced-endpoint flag.
// Shared between the wirelength walk and the placer's legality check.
module manhattan_len
  import placement_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic signed [COORD_W-1:0] xa,
  input  logic signed [COORD_W-1:0] ya,
  input  logic signed [COORD_W-1:0] xb,
  input  logic signed [COORD_W-1:0] yb,
  output logic        [COORD_W+1:0] len,
  output logic                      unplaced
);

  localparam int LW = COORD_W + 2;

  logic signed [LW-1:0] dx, dy, adx, ady, raw;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    // Two guard bits keep |dx|+|dy| of two full-range signed coordinates exact.
    dx  = {{2{xa[COORD_W-1]}}, xa} - {{2{xb[COORD_W-1]}}, xb};
    dy  = {{2{ya[COORD_W-1]}}, ya} - {{2{yb[COORD_W-1]}}, yb};
    adx = dx[LW-1] ? -dx : dx;
    ady = dy[LW-1] ? -dy : dy;
    raw = adx + ady - LW'(1);
    len = raw[LW-1] ? '0 : raw;
    unplaced = (&xa) | (&ya) | (&xb) | (&yb);
  end

endmodule

// File: rtl/placement_cost.sv
// Wirelength evaluator: walks the edge list, fetches both endpoints and sums clamped
// Manhattan lengths with saturation. Define PLACE_COST_MAXLEN_EN to add the max_len report.
module placement_cost
  import placement_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COORD_W = DEF_COORD_W,
  parameter int SUM_W   = DEF_SUM_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic        [ADDR_W-1:0]  num_edges,
  output logic                      busy,
  output logic                      done,
  output logic                      edge_re,
  output logic        [ADDR_W-1:0]  edge_addr,
  input  logic        [ADDR_W-1:0]  edge_a,
  input  logic        [ADDR_W-1:0]  edge_b,
  output logic                      pos_re,
  output logic        [ADDR_W-1:0]  pos_addr,
  input  logic signed [COORD_W-1:0] pos_x,
  input  logic signed [COORD_W-1:0] pos_y,
  output logic        [SUM_W-1:0]   cost,
  output logic                      unplaced,
  output logic                      overflow
`ifdef PLACE_COST_MAXLEN_EN
  ,
  output logic        [SUM_W-1:0]   max_len
`endif
);

  localparam int LEN_W = COORD_W + 2;
  localparam int ACC_W = ((SUM_W > LEN_W) ? SUM_W : LEN_W) + 1;
  localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  state_t                    state;
  logic        [ADDR_W-1:0]  n_edges;
  logic        [ADDR_W-1:0]  idx;
  logic        [ADDR_W-1:0]  idx_next;
  logic        [ADDR_W-1:0]  node_b;
  logic signed [COORD_W-1:0] xa, ya, xb, yb;
  logic        [LEN_W-1:0]   len;
  logic                      edge_unplaced;
  logic        [ACC_W-1:0]   sum;
  logic                      sum_sat;

  manhattan_len #(
    .COORD_W(COORD_W)
  ) u_len (
    .xa      (xa),
    .ya      (ya),
    .xb      (xb),
    .yb      (yb),
    .len     (len),
    .unplaced(edge_unplaced)
  );

  // The sum is formed one bit wider than either operand so saturation is a plain compare.
  always_comb begin
    idx_next = idx + ADDR_W'(1);
    sum      = ACC_W'(cost) + ACC_W'(len);
    sum_sat  = sum > SUM_MAX;
  end

`ifdef PLACE_COST_MAXLEN_EN
  logic [ACC_W-1:0] len_acc;
  logic [SUM_W-1:0] len_clip;

  always_comb begin
    len_acc  = ACC_W'(len);
    len_clip = (len_acc > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : len_acc[SUM_W-1:0];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      edge_re   <= 1'b0;
      edge_addr <= '0;
      pos_re    <= 1'b0;
      pos_addr  <= '0;
      cost      <= '0;
      unplaced  <= 1'b0;
      overflow  <= 1'b0;
      n_edges   <= '0;
      idx       <= '0;
      node_b    <= '0;
      xa        <= '0;
      ya        <= '0;
      xb        <= '0;
      yb        <= '0;
`ifdef PLACE_COST_MAXLEN_EN
      max_len   <= '0;
`endif
    end else begin
      edge_re <= 1'b0;
      pos_re  <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            n_edges  <= num_edges;
            idx      <= '0;
            cost     <= '0;
            unplaced <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
`ifdef PLACE_COST_MAXLEN_EN
            max_len  <= '0;
`endif
            if (num_edges == '0) begin
              state <= FIN;
            end else begin
              state     <= E_RD;
              edge_re   <= 1'b1;
              edge_addr <= '0;
            end
          end
        end

        E_RD: state <= E_WT;

        // Endpoint a goes straight onto the position address; b waits its turn.
        E_WT: begin
          pos_addr <= edge_a;
          node_b   <= edge_b;
          pos_re   <= 1'b1;
          state    <= A_RD;
        end

        A_RD: state <= A_WT;

        A_WT: begin
          xa       <= pos_x;
          ya       <= pos_y;
          pos_addr <= node_b;
          pos_re   <= 1'b1;
          state    <= B_RD;
        end

        B_RD: state <= B_WT;

        B_WT: begin
          xb    <= pos_x;
          yb    <= pos_y;
          state <= ACC;
        end

        ACC: begin
          if (edge_unplaced) begin
            unplaced <= 1'b1;
          end else begin
            if (sum_sat) begin
              cost     <= SUM_MAX[SUM_W-1:0];
              overflow <= 1'b1;
            end else begin
              cost <= sum[SUM_W-1:0];
            end
`ifdef PLACE_COST_MAXLEN_EN
            if (len_acc > ACC_W'(max_len)) max_len <= len_clip;
`endif
          end
          idx <= idx_next;
          if (idx_next == n_edges) begin
            state <= FIN;
          end else begin
            state     <= E_RD;
            edge_re   <= 1'b1;
            edge_addr <= idx_next;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
